// File: rtl/keypad_scan_unit_pkg.sv
// Shared definitions for the keypad scanner: geometry, FSM encoding and the
// sweep classifier that turns a 16-bit contact snapshot into a key decision.
package keypad_scan_unit_pkg;

    localparam int ROWS   = 4;
    localparam int COLS   = 4;
    localparam int CODE_W = 4;
    localparam int SNAP_W = ROWS * COLS;

    // Column dwell shared with the segment display scanner (1 ms at 100 MHz).
    localparam int DEFAULT_SCAN_CNT_MAX = 100000;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_PRESSED  = 2'd2;
    localparam logic [1:0] ST_RELEASE  = 2'd3;

    typedef enum logic [1:0] {
        CLS_NONE   = 2'd0,
        CLS_SINGLE = 2'd1,
        CLS_MULTI  = 2'd2
    } cls_kind_e;

    typedef struct packed {
        cls_kind_e          kind;
        logic [CODE_W-1:0]  code;
    } cls_t;

    // Snapshot bit index is col*4+row; the reported code is row*4+col.
    function automatic cls_t classify(input logic [SNAP_W-1:0] snap);
        cls_t       res;
        logic [4:0] cnt;
        logic [3:0] idx;
        res.kind = CLS_NONE;
        res.code = 4'd0;
        cnt      = 5'd0;
        for (int i = 0; i < SNAP_W; i++) begin
            idx = 4'(i);
            if (snap[i]) begin
                cnt      = cnt + 5'd1;
                res.code = {idx[1:0], idx[3:2]};
            end else begin
                cnt      = cnt;
            end
        end
        if (cnt == 5'd0) begin
            res.kind = CLS_NONE;
            res.code = 4'd0;
        end else if (cnt == 5'd1) begin
            res.kind = CLS_SINGLE;
        end else begin
            res.kind = CLS_MULTI;
            res.code = 4'd0;
        end
        return res;
    endfunction

endpackage

// File: rtl/keypad_scan_unit_if.sv
// Pin-side and result-side signals of the keypad scanner; the unit is the slave.
interface keypad_scan_unit_if;
    import keypad_scan_unit_pkg::*;

    logic [ROWS-1:0]   row_in;
    logic [COLS-1:0]   col_out;
    logic [CODE_W-1:0] key_code;
    logic              key_valid;
    logic              key_held;

    modport slave (
        input  row_in,
        output col_out,
        output key_code,
        output key_valid,
        output key_held
    );

    modport master (
        output row_in,
        input  col_out,
        input  key_code,
        input  key_valid,
        input  key_held
    );
endinterface

// File: rtl/keypad_scan_unit_scan_tick_gen.sv
// Free-running dwell counter producing a registered one-clock tick every
// SCAN_CNT_MAX+1 clocks; also usable by the display scanner.
module scan_tick_gen #(
    parameter int SCAN_CNT_MAX = 100000
) (
    input  logic clk,
    input  logic rst,
    output logic tick_o
);
    localparam int CNT_W = (SCAN_CNT_MAX > 0) ? $clog2(SCAN_CNT_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX_C = CNT_W'(SCAN_CNT_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE_C = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             tick_q;
    logic             tick_d;

    // Next count with wrap, and tick flag for the cycle after the terminal count.
    always_comb begin
        if (cnt_q == CNT_MAX_C) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end else begin
            cnt_d  = cnt_q + CNT_ONE_C;
            tick_d = 1'b0;
        end
    end

    // Counter and tick registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/keypad_scan_unit.sv
// 4x4 matrix keypad reader: one-cold column scan, end-of-dwell row sampling,
// sweep-level debounce of press and release, one-cycle valid per press.
module keypad_scan_unit
    import keypad_scan_unit_pkg::*;
#(
    parameter int SCAN_CNT_MAX    = DEFAULT_SCAN_CNT_MAX,
    parameter int DEBOUNCE_SWEEPS = 4
) (
    input  logic             clk,
    input  logic             rst,
    keypad_scan_unit_if.slave kp
);
    localparam int DBC_W = $clog2(DEBOUNCE_SWEEPS + 1);
    localparam logic [DBC_W-1:0] DBC_ONE    = DBC_W'(1);
    localparam logic [DBC_W-1:0] DBC_TARGET = DBC_W'(DEBOUNCE_SWEEPS);
    localparam bit               FIRST_OK   = (DEBOUNCE_SWEEPS <= 1);

    logic [ROWS-1:0]   row_meta_q;
    logic [ROWS-1:0]   row_sync_q;
    logic              tick_s;
    logic              sweep_end_s;
    logic [1:0]        col_idx_q,  col_idx_d;
    logic [COLS-1:0]   col_out_q,  col_out_d;
    logic [SNAP_W-1:0] snap_q,     snap_d;
    logic [1:0]        state_q,    state_d;
    logic [CODE_W-1:0] cand_q,     cand_d;
    logic [DBC_W-1:0]  dbc_q,      dbc_d;
    logic [DBC_W-1:0]  dbc_inc_s;
    logic [CODE_W-1:0] key_code_q, key_code_d;
    logic              key_valid_q, key_valid_d;
    logic              key_held_q,  key_held_d;
    cls_t              cls_s;
    logic              is_cand_s;

    scan_tick_gen #(
        .SCAN_CNT_MAX (SCAN_CNT_MAX)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .tick_o (tick_s)
    );

    // Two-flop synchronizer for the asynchronous row pins.
    always_ff @(posedge clk) begin
        if (!rst) begin
            row_meta_q <= 4'b1111;
            row_sync_q <= 4'b1111;
        end else begin
            row_meta_q <= kp.row_in;
            row_sync_q <= row_meta_q;
        end
    end

    // Column advance, column drive and snapshot capture of the column just dwelt on.
    always_comb begin
        snap_d = snap_q;
        if (tick_s) begin
            col_idx_d = col_idx_q + 2'd1;
            snap_d[{col_idx_q, 2'b00} +: ROWS] = ~row_sync_q;
        end else begin
            col_idx_d = col_idx_q;
        end
        col_out_d = ~(4'b0001 << col_idx_d);
    end

    assign sweep_end_s = tick_s && (col_idx_q == 2'd3);
    assign cls_s       = classify(snap_d);
    assign is_cand_s   = (cls_s.kind == CLS_SINGLE) && (cls_s.code == cand_q);
    assign dbc_inc_s   = dbc_q + DBC_ONE;

    // Debounce FSM; evaluated only on the tick that completes a full sweep.
    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        dbc_d       = dbc_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
        if (sweep_end_s) begin
            case (state_q)
                ST_IDLE: begin
                    if (cls_s.kind == CLS_SINGLE) begin
                        cand_d = cls_s.code;
                        if (FIRST_OK) begin
                            state_d     = ST_PRESSED;
                            key_code_d  = cls_s.code;
                            key_valid_d = 1'b1;
                            key_held_d  = 1'b1;
                            dbc_d       = '0;
                        end else begin
                            state_d = ST_DEBOUNCE;
                            dbc_d   = DBC_ONE;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_DEBOUNCE: begin
                    if (is_cand_s) begin
                        if (dbc_inc_s >= DBC_TARGET) begin
                            state_d     = ST_PRESSED;
                            key_code_d  = cand_q;
                            key_valid_d = 1'b1;
                            key_held_d  = 1'b1;
                            dbc_d       = '0;
                        end else begin
                            dbc_d = dbc_inc_s;
                        end
                    end else begin
                        state_d = ST_IDLE;
                        dbc_d   = '0;
                    end
                end
                ST_PRESSED: begin
                    if (is_cand_s) begin
                        state_d = ST_PRESSED;
                    end else if (cls_s.kind == CLS_NONE) begin
                        if (FIRST_OK) begin
                            state_d    = ST_IDLE;
                            key_held_d = 1'b0;
                            dbc_d      = '0;
                        end else begin
                            state_d = ST_RELEASE;
                            dbc_d   = DBC_ONE;
                        end
                    end else begin
                        state_d = ST_RELEASE;
                        dbc_d   = '0;
                    end
                end
                ST_RELEASE: begin
                    if (cls_s.kind == CLS_NONE) begin
                        if (dbc_inc_s >= DBC_TARGET) begin
                            state_d    = ST_IDLE;
                            key_held_d = 1'b0;
                            dbc_d      = '0;
                        end else begin
                            dbc_d = dbc_inc_s;
                        end
                    end else if (is_cand_s) begin
                        state_d = ST_PRESSED;
                        dbc_d   = '0;
                    end else begin
                        dbc_d = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    dbc_d   = '0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Scan, snapshot, FSM and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            col_idx_q   <= 2'd0;
            col_out_q   <= 4'b1111;
            snap_q      <= '0;
            state_q     <= ST_IDLE;
            cand_q      <= 4'd0;
            dbc_q       <= '0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            col_idx_q   <= col_idx_d;
            col_out_q   <= col_out_d;
            snap_q      <= snap_d;
            state_q     <= state_d;
            cand_q      <= cand_d;
            dbc_q       <= dbc_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign kp.col_out   = col_out_q;
    assign kp.key_code  = key_code_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scan_unit.sv
// Self-checking bench for keypad_scan_unit with a combinational keypad model and
// a sweep-level reference model of press/release debouncing.
module tb_keypad_scan_unit;
    localparam int SCM    = 9;
    localparam int DS     = 3;
    localparam int SWEEP  = 4 * (SCM + 1);

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] keys = 16'h0000;   // bit index = row*4+col
    int          total = 0;
    int          bad   = 0;
    int          pulses = 0;

    bit          m_held;
    bit          m_valid;
    logic [3:0]  m_code;
    logic [3:0]  m_cand;
    int          m_run;
    int          m_rel;

    typedef struct {
        logic [15:0] k;
        logic        v;
        logic        h;
        logic [3:0]  c;
    } vec_t;
    vec_t tbl [8];

    always #5 clk = ~clk;

    keypad_scan_unit_if kif();

    keypad_scan_unit #(
        .SCAN_CNT_MAX    (SCM),
        .DEBOUNCE_SWEEPS (DS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kif)
    );

    // A closed key pulls its row low only while its column is driven low.
    always_comb begin
        kif.row_in = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !kif.col_out[c]) kif.row_in[r] = 1'b0;
    end

    function automatic logic [15:0] kb(input int n);
        logic [15:0] one;
        one = 16'h0001;
        return one << n;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_held = 0; m_valid = 0; m_code = 4'd0; m_cand = 4'd0; m_run = 0; m_rel = 0;
    endtask

    // One sweep's worth of decision, stated in terms of streaks of identical sweeps.
    task automatic model_sweep(input logic [15:0] k);
        int n;
        logic [3:0] code;
        n = $countones(k);
        code = 4'd0;
        for (int i = 0; i < 16; i++) if (k[i]) code = 4'(i);
        m_valid = 0;
        if (!m_held) begin
            if (n == 1) begin
                if (m_run == 0) begin m_cand = code; m_run = 1; end
                else if (code == m_cand) m_run++;
                else m_run = 0;
            end else m_run = 0;
            if (m_run >= DS) begin
                m_valid = 1; m_held = 1; m_code = m_cand; m_run = 0; m_rel = 0;
            end
        end else begin
            if (n == 1 && code == m_cand) m_rel = 0;
            else if (n == 0) begin
                m_rel++;
                if (m_rel >= DS) begin m_held = 0; m_rel = 0; end
            end else m_rel = 0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_col_out", int'(kif.col_out), 15);
        check("rst_key_code", int'(kif.key_code), 0);
        check("rst_key_valid", int'(kif.key_valid), 0);
        check("rst_key_held", int'(kif.key_held), 0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        check("first_col_out", int'(kif.col_out), 14);
    endtask

    // Applies a key set for exactly one sweep, checking every clock.
    task automatic do_sweep(input logic [15:0] k);
        logic [3:0] exp_col;
        keys = k;
        for (int i = 1; i <= SWEEP; i++) begin
            @(negedge clk);
            if (i == SWEEP) model_sweep(k);
            exp_col = 4'b1111 ^ (4'b0001 << ((i / (SCM + 1)) % 4));
            if (kif.key_valid) pulses++;
            check("col_out", int'(kif.col_out), int'(exp_col));
            check("key_valid", int'(kif.key_valid), (i == SWEEP) ? int'(m_valid) : 0);
            check("key_held", int'(kif.key_held), int'(m_held));
            check("key_code", int'(kif.key_code), int'(m_code));
        end
    endtask

    task automatic sweeps(input logic [15:0] k, input int n);
        for (int i = 0; i < n; i++) do_sweep(k);
    endtask

    initial begin
        int p0;
        logic [15:0] prev, k;

        tbl[0] = '{kb(9), 1'b0, 1'b0, 4'd0};
        tbl[1] = '{kb(9), 1'b0, 1'b0, 4'd0};
        tbl[2] = '{kb(9), 1'b1, 1'b1, 4'd9};
        tbl[3] = '{kb(9), 1'b0, 1'b1, 4'd9};
        tbl[4] = '{kb(9), 1'b0, 1'b1, 4'd9};
        tbl[5] = '{16'h0000, 1'b0, 1'b1, 4'd9};
        tbl[6] = '{16'h0000, 1'b0, 1'b1, 4'd9};
        tbl[7] = '{16'h0000, 1'b0, 1'b0, 4'd9};

        do_reset();

        for (int i = 0; i < 8; i++) begin
            do_sweep(tbl[i].k);
            check("tbl_valid", int'(kif.key_valid), int'(tbl[i].v));
            check("tbl_held", int'(kif.key_held), int'(tbl[i].h));
            check("tbl_code", int'(kif.key_code), int'(tbl[i].c));
        end

        // Long hold: one pulse only.
        p0 = pulses;
        sweeps(kb(9), 23);
        check("hold_pulses", pulses - p0, 1);
        sweeps(16'h0000, 3);
        check("hold_release", int'(kif.key_held), 0);

        // Bounce: present/absent on alternate sweeps, then steady.
        p0 = pulses;
        for (int i = 0; i < 10; i++) do_sweep((i % 2 == 0) ? kb(5) : 16'h0000);
        check("bounce_pulses", pulses - p0, 0);
        sweeps(kb(5), 3);
        check("bounce_steady_pulses", pulses - p0, 1);
        check("bounce_code", int'(kif.key_code), 5);
        sweeps(16'h0000, 3);

        // Ghost: two keys are rejected, the survivor is accepted.
        p0 = pulses;
        sweeps(kb(0) | kb(15), 5);
        check("ghost_pulses", pulses - p0, 0);
        sweeps(kb(0), 3);
        check("ghost_single_pulses", pulses - p0, 1);
        check("ghost_code", int'(kif.key_code), 0);
        sweeps(16'h0000, 3);

        // Rollover: a second key never reports until a full release.
        sweeps(kb(3), 3);
        check("roll_code3", int'(kif.key_code), 3);
        p0 = pulses;
        sweeps(kb(3) | kb(12), 3);
        sweeps(kb(12), 5);
        check("roll_no_pulse", pulses - p0, 0);
        sweeps(16'h0000, 3);
        sweeps(kb(12), 3);
        check("roll_pulse12", pulses - p0, 1);
        check("roll_code12", int'(kif.key_code), 12);
        sweeps(16'h0000, 3);

        // Reset while held: key reported again after a fresh debounce.
        sweeps(kb(7), 4);
        check("pre_rst_held", int'(kif.key_held), 1);
        p0 = pulses;
        do_reset();
        sweeps(kb(7), 3);
        check("post_rst_pulse", pulses - p0, 1);
        check("post_rst_code", int'(kif.key_code), 7);
        sweeps(16'h0000, 3);

        // Randomized sweeps against the model.
        prev = 16'h0000;
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 5))
                0:       k = 16'h0000;
                1:       k = kb(int'($urandom_range(0, 15)));
                5:       k = kb(int'($urandom_range(0, 15))) | kb(int'($urandom_range(0, 15)));
                default: k = prev;
            endcase
            if (i % 10 == 0) k = kb(int'($urandom_range(0, 15)));
            do_sweep(k);
            prev = k;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/keypad_scan_unit.md
Name: keypad_scan_unit

Overview:
- Scanning reader for a 4x4 matrix keypad. It is the input-side counterpart of the 8-digit segment scanner.
- It drives one column low at a time, samples the active-low rows, and debounces across full sweeps.
- It reports a single key press as a 4-bit code with a one-cycle valid pulse.
- It sits between the board keypad pins and the command/display logic next to the UART and display units.

Parameters:
SCAN_CNT_MAX, 100000, column dwell: a tick occurs every SCAN_CNT_MAX+1 clocks (1 ms at 100 MHz).
DEBOUNCE_SWEEPS, 4, number of consecutive identical full sweeps needed to accept a press or a release.

Ports:
clk  input  1  system clock.
rst  input  1  synchronous reset, active-low (0 = reset, sampled on posedge clk only).
row_in  input  4  keypad rows, externally pulled up; 0 = key closed on the driven column; asynchronous to clk.
col_out  output  4  column drive, one-cold; bit c low selects column c.
key_code  output  4  code of the last accepted key = row*4 + col.
key_valid  output  1  one-clock pulse when a press is accepted; key_code is valid in the same cycle and holds afterwards.
key_held  output  1  high from acceptance until the release is debounced.

Behaviour:
- Reset values (rst=0 at posedge): col_out=4'b1111, key_code=0, key_valid=0, key_held=0, FSM=IDLE, all counters and snapshot cleared.
- Synchronizer: row_in passes through 2 flops (reset value 4'b1111); only row_sync is used.
- Tick generator:
  - cnt counts 0..SCAN_CNT_MAX and wraps to 0.
  - tick is a registered flag, high for one clock in the cycle after cnt==SCAN_CNT_MAX.
- Column drive:
  - col_idx[1:0] starts at 0 and increments on tick, wrapping 3->0.
  - col_out = ~(1<<col_idx), registered. It reads 4'b1110 on the first clock after reset release.
- Sampling:
  - On tick, before col_idx advances, ~row_sync is stored into snapshot bits [col_idx*4 +: 4] (bit index = col*4+row).
  - Sampling at the end of each dwell allows at least SCAN_CNT_MAX clocks for the pins and synchronizer to settle.
- Sweep end: the tick with col_idx==3. The classifier reads the full snapshot including the column-3 row sample.
  - NONE: no bits set.
  - SINGLE(code): exactly one bit set; code = row*4+col.
  - MULTI: two or more bits set, treated as ghosting/invalid.
- FSM advances only at sweep ends; dbc is a counter sized for DEBOUNCE_SWEEPS.
  - IDLE:
    - SINGLE(k): cand=k, dbc=1, go to DEBOUNCE.
    - Otherwise stay.
  - DEBOUNCE:
    - SINGLE(cand): dbc++. When dbc reaches DEBOUNCE_SWEEPS: go to PRESSED, key_code<=cand, key_valid=1 for one clock, key_held<=1.
    - SINGLE(other) or MULTI: go to IDLE.
    - NONE: go to IDLE.
    - DEBOUNCE_SWEEPS=1 accepts on the first sweep, going from IDLE straight to PRESSED.
  - PRESSED:
    - SINGLE(cand): stay.
    - Anything else: dbc=1 if NONE, else dbc=0; go to RELEASE.
  - RELEASE:
    - NONE: dbc++. When dbc reaches DEBOUNCE_SWEEPS: go to IDLE, key_held<=0.
    - SINGLE(cand): go back to PRESSED. No new key_valid.
    - SINGLE(other) or MULTI: dbc=0, stay in RELEASE.
- Behaviour guarantees:
  - A held key produces exactly one key_valid per press-release cycle, regardless of hold length.
  - A second key pressed while one is held is never reported until a full release is debounced.
- Reset mid-operation: all state clears immediately. A key still held after reset is reported again after a fresh debounce.
- Press latency: from row contact to key_valid is at most (DEBOUNCE_SWEEPS+1)*4*(SCAN_CNT_MAX+1)+4 clocks.

Decomposition:
- Shared package:
  - FSM state encoding (IDLE/DEBOUNCE/PRESSED/RELEASE, 2 bits).
  - Keypad geometry constants (ROWS=4, COLS=4, CODE_W=4).
  - Default SCAN_CNT_MAX reused from the display scanner.
- One natural sub-module, scan_tick_gen: counter plus registered tick, parameterized by SCAN_CNT_MAX. The display scanner can reuse it.
- Synchronizer, classifier and FSM stay inline.

Test Plan:
- Test setup: SCAN_CNT_MAX=9, DEBOUNCE_SWEEPS=3 (sweep = 40 clocks). The bench models the keypad combinationally: row_in[r] = 0 iff key(r,c) is closed and col_out[c]==0.
- Reset/scan: rst=0 -> col_out=1111 and all outputs 0. After release, col_out cycles 1110,1101,1011,0111 with 10 clocks each, wrapping.
- Clean press: close row 2/col 1 -> exactly one key_valid with key_code=9 after the 3rd consecutive matching sweep, and key_held=1. Hold for 20 sweeps -> no further pulses. Open -> key_held falls after 3 NONE sweeps.
- Bounce: toggle key 5 so that it is alternately present and absent on successive sweeps for 10 sweeps -> no key_valid. Then hold steady -> one pulse with code 5.
- Ghost/two keys: close keys 0 and 15 together -> no key_valid. Release 15 only -> key 0 is accepted after 3 sweeps, code 0.
- Rollover: hold key 3 until accepted, press key 12 as well, release 3 and keep 12 -> no pulse for 12 while any key is down. Release all, re-press 12 -> pulse with code 12.
- Reset mid-hold: hold key 7 in PRESSED, assert rst=0 for 2 clocks -> key_held=0, key_code=0. Key still held -> key_valid with code 7 again after 3 sweeps.
